// File: rtl/data_cache_pkg.sv
// cache_pkg: shared FSM state type, address-geometry helpers and field extraction for data_cache.
`default_nettype none

package cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2
  } cache_state_e;

  function automatic int byte_off_bits(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int word_off_bits(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int index_bits(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_bits(input int addr_w, input int data_w,
                                  input int lines, input int words_per_line);
    return addr_w - byte_off_bits(data_w) - word_off_bits(words_per_line) - index_bits(lines);
  endfunction

  // Storage widths must stay >= 1 even when a field collapses to zero bits.
  function automatic int min1(input int w);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int DEF_TAG_W   = tag_bits(32, 32, 16, 4);
  localparam int DEF_INDEX_W = index_bits(16);
  localparam int DEF_WORD_W  = word_off_bits(4);

  function automatic logic [63:0] addr_field(input logic [63:0] addr, input int lsb, input int width);
    logic [63:0] mask;
    mask = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    return (addr >> lsb) & mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/data_cache_if.sv
// data_cache_if: CPU request/response and backing-store handshake signals of data_cache.
`default_nettype none

interface data_cache_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writeData;
  logic              memWrite;
  logic              memRead;
  logic [DATA_W-1:0] readData;
  logic              stall;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output address, writeData, memWrite, memRead, mem_rdata, mem_ready,
    input  readData, stall, mem_addr, mem_wdata, mem_read, mem_write
  );

  modport slave (
    input  address, writeData, memWrite, memRead, mem_rdata, mem_ready,
    output readData, stall, mem_addr, mem_wdata, mem_read, mem_write
  );
endinterface

`default_nettype wire

// File: rtl/cache_line_array.sv
// cache_line_array: valid/tag/data storage with a combinational read port and one synchronous write port.
`default_nettype none

module cache_line_array #(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int DATA_W         = 32,
  parameter int TAG_W          = 26,
  parameter int IDX_W          = 4,
  parameter int WRD_W          = 2
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic [IDX_W-1:0]  i_rd_index,
  input  wire logic [WRD_W-1:0]  i_rd_word,
  output logic      [TAG_W-1:0]  o_rd_tag,
  output logic                   o_rd_valid,
  output logic      [DATA_W-1:0] o_rd_word,
  input  wire logic              i_wr_en,
  input  wire logic [IDX_W-1:0]  i_wr_index,
  input  wire logic [WRD_W-1:0]  i_wr_word,
  input  wire logic [DATA_W-1:0] i_wr_data,
  input  wire logic              i_set_en,
  input  wire logic [TAG_W-1:0]  i_set_tag
);

  logic [LINES-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [DATA_W-1:0] r_data [LINES][WORDS_PER_LINE];

  assign o_rd_valid = r_valid[i_rd_index];
  assign o_rd_tag   = r_tag[i_rd_index];
  assign o_rd_word  = r_data[i_rd_index][i_rd_word];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_set_en) begin
      r_valid[i_wr_index] <= 1'b1;
    end
  end

  // Tags and data are deliberately left unreset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (i_set_en) begin
      r_tag[i_wr_index] <= i_set_tag;
    end
    if (i_wr_en) begin
      r_data[i_wr_index][i_wr_word] <= i_wr_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/data_cache.sv
// data_cache: direct-mapped write-through, no-write-allocate cache with a word-wide request/ready memory port.
// Optional hit/miss statistics outputs are enabled by defining CACHE_STATS_EN.
`default_nettype none

module data_cache
  import cache_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  wire logic        clk,
  input  wire logic        rst,
  data_cache_if.slave      bus
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]      hit_count,
  output logic [31:0]      miss_count
`endif
);

  localparam int c_BYTE_BITS  = byte_off_bits(DATA_W);
  localparam int c_WORD_BITS  = word_off_bits(WORDS_PER_LINE);
  localparam int c_INDEX_BITS = index_bits(LINES);
  localparam int c_TAG_W      = tag_bits(ADDR_W, DATA_W, LINES, WORDS_PER_LINE);
  localparam int c_WORD_LSB   = c_BYTE_BITS;
  localparam int c_INDEX_LSB  = c_BYTE_BITS + c_WORD_BITS;
  localparam int c_TAG_LSB    = c_INDEX_LSB + c_INDEX_BITS;
  localparam int c_IDX_W      = min1(c_INDEX_BITS);
  localparam int c_WRD_W      = min1(c_WORD_BITS);
  localparam logic [c_WRD_W-1:0] c_LAST_BEAT = c_WRD_W'(WORDS_PER_LINE - 1);
  localparam logic [ADDR_W-1:0]  c_LINE_MASK = ADDR_W'((64'd1 << c_INDEX_LSB) - 64'd1);

  cache_state_e        r_state;
  cache_state_e        w_next;
  logic [c_WRD_W-1:0]  r_beat;
  logic                r_done;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;

  logic [c_TAG_W-1:0]  w_tag;
  logic [c_IDX_W-1:0]  w_index;
  logic [c_WRD_W-1:0]  w_word;
  logic [c_TAG_W-1:0]  w_r_tag;
  logic [c_IDX_W-1:0]  w_r_index;
  logic [ADDR_W-1:0]   w_line_base;

  logic                w_load;
  logic                w_store;
  logic                w_req;
  logic                w_hit;
  logic                w_idle_active;
  logic                w_hit_evt;
  logic                w_last_beat;
  logic                w_capture;

  logic [c_TAG_W-1:0]  w_rd_tag;
  logic                w_rd_valid;
  logic [DATA_W-1:0]   w_rd_word;
  logic                w_arr_we;
  logic                w_arr_set;
  logic [c_IDX_W-1:0]  w_arr_idx;
  logic [c_WRD_W-1:0]  w_arr_word;
  logic [DATA_W-1:0]   w_arr_data;

  assign w_tag     = c_TAG_W'(addr_field(64'(bus.address), c_TAG_LSB, c_TAG_W));
  assign w_index   = c_IDX_W'(addr_field(64'(bus.address), c_INDEX_LSB, c_INDEX_BITS));
  assign w_word    = c_WRD_W'(addr_field(64'(bus.address), c_WORD_LSB, c_WORD_BITS));
  assign w_r_tag   = c_TAG_W'(addr_field(64'(r_addr), c_TAG_LSB, c_TAG_W));
  assign w_r_index = c_IDX_W'(addr_field(64'(r_addr), c_INDEX_LSB, c_INDEX_BITS));
  assign w_line_base = r_addr & ~c_LINE_MASK;

  // A simultaneous read+write request is a store only.
  assign w_store       = bus.memWrite;
  assign w_load        = bus.memRead & ~bus.memWrite;
  assign w_req         = bus.memRead | bus.memWrite;
  assign w_hit         = w_rd_valid && (w_rd_tag == w_tag);
  assign w_idle_active = (r_state == IDLE) && !r_done;
  assign w_hit_evt     = w_idle_active && w_load && w_hit;
  assign w_last_beat   = (r_beat == c_LAST_BEAT);

  cache_line_array #(
    .LINES          (LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .DATA_W         (DATA_W),
    .TAG_W          (c_TAG_W),
    .IDX_W          (c_IDX_W),
    .WRD_W          (c_WRD_W)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .i_rd_index (w_index),
    .i_rd_word  (w_word),
    .o_rd_tag   (w_rd_tag),
    .o_rd_valid (w_rd_valid),
    .o_rd_word  (w_rd_word),
    .i_wr_en    (w_arr_we),
    .i_wr_index (w_arr_idx),
    .i_wr_word  (w_arr_word),
    .i_wr_data  (w_arr_data),
    .i_set_en   (w_arr_set),
    .i_set_tag  (w_r_tag)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_capture  = 1'b0;
    w_arr_we   = 1'b0;
    w_arr_set  = 1'b0;
    w_arr_idx  = w_index;
    w_arr_word = w_word;
    w_arr_data = bus.writeData;
    case (r_state)
      IDLE: begin
        // The completion cycle after a write accepts no new request.
        if (!r_done) begin
          if (w_store) begin
            w_next    = WRITE;
            w_capture = 1'b1;
            w_arr_we  = w_hit;
          end else if (w_load && !w_hit) begin
            w_next    = REFILL;
            w_capture = 1'b1;
          end
        end
      end
      REFILL: begin
        if (bus.mem_ready) begin
          w_arr_we   = 1'b1;
          w_arr_idx  = w_r_index;
          w_arr_word = r_beat;
          w_arr_data = bus.mem_rdata;
          if (w_last_beat) begin
            w_arr_set = 1'b1;
            w_next    = IDLE;
          end
        end
      end
      WRITE: begin
        if (bus.mem_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat  <= '0;
      r_done  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_done <= (r_state == WRITE) && bus.mem_ready;
      if (w_capture) begin
        r_addr  <= bus.address;
        r_wdata <= bus.writeData;
        r_beat  <= '0;
      end else if ((r_state == REFILL) && bus.mem_ready) begin
        r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
      end
    end
  end

  assign bus.stall     = w_req && !w_hit_evt && !r_done;
  assign bus.readData  = w_hit_evt ? w_rd_word : '0;
  assign bus.mem_read  = (r_state == REFILL);
  assign bus.mem_write = (r_state == WRITE);
  assign bus.mem_wdata = (r_state == WRITE) ? r_wdata : '0;

  always_comb begin
    bus.mem_addr = '0;
    if (r_state == REFILL) begin
      bus.mem_addr = w_line_base | (ADDR_W'(r_beat) << c_BYTE_BITS);
    end else if (r_state == WRITE) begin
      bus.mem_addr = r_addr;
    end
  end

`ifdef CACHE_STATS_EN
  logic w_miss_evt;
  assign w_miss_evt = w_idle_active && w_load && !w_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (w_hit_evt && (hit_count != '1)) begin
        hit_count <= hit_count + 32'd1;
      end
      if (w_miss_evt && (miss_count != '1)) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_data_cache.sv
// tb_data_cache: directed self-checking bench for data_cache with a 2-cycle request/ready memory model.
`default_nettype none

module tb_data_cache;

  logic clk = 1'b0;
  logic rst;
  logic mem_clr;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  data_cache_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  data_cache dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef CACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  // Backing store: unwritten words read as A5A5_<low address>; each beat takes 2 cycles.
  logic [31:0]   mem [0:1023];
  logic [1023:0] written;
  int            cnt;
  logic [31:0]   rd_log [$];
  int            wr_cnt = 0;
  logic [31:0]   last_wr_addr = '0;
  logic [31:0]   last_wr_data = '0;
  logic          both_seen = 1'b0;

  assign bus.mem_ready = (bus.mem_read || bus.mem_write) && (cnt == 1);
  assign bus.mem_rdata = written[bus.mem_addr[11:2]] ? mem[bus.mem_addr[11:2]]
                                                     : (32'hA5A5_0000 | {20'd0, bus.mem_addr[11:0]});

  always @(posedge clk or posedge rst) begin
    if (rst) cnt <= 0;
    else if ((bus.mem_read || bus.mem_write) && !bus.mem_ready) cnt <= cnt + 1;
    else cnt <= 0;
  end

  always @(posedge clk) begin
    if (mem_clr) begin
      written <= '0;
    end else if (!rst) begin
      if (bus.mem_write && bus.mem_ready) begin
        mem[bus.mem_addr[11:2]]     <= bus.mem_wdata;
        written[bus.mem_addr[11:2]] <= 1'b1;
        wr_cnt       <= wr_cnt + 1;
        last_wr_addr <= bus.mem_addr;
        last_wr_data <= bus.mem_wdata;
      end
      if (bus.mem_read && bus.mem_ready) rd_log.push_back(bus.mem_addr);
      if (bus.mem_read && bus.mem_write) both_seen <= 1'b1;
    end
  end

  task automatic cpu_op(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] first_rdata, output logic [31:0] rdata, output int cyc);
    @(negedge clk);
    bus.address = a; bus.writeData = d; bus.memRead = rd; bus.memWrite = wr;
    cyc = 0;
    #1;
    first_rdata = bus.readData;
    while (bus.stall && cyc < 200) begin
      @(negedge clk); #1; cyc++;
    end
    n_vec++;
    if (cyc >= 200) begin
      n_bad++;
      $display("FAIL op_timeout addr=%h: stall still high after %0d cycles, required to drop", a, cyc);
    end
    rdata = bus.readData;
    @(posedge clk); #1;
    bus.memRead = 1'b0; bus.memWrite = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_clr = 1'b1;
    bus.address = '0; bus.writeData = '0; bus.memRead = 1'b0; bus.memWrite = 1'b0;
    repeat (2) @(negedge clk);
    mem_clr = 1'b0;
    #1;
    n_vec++; if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %b need 0", bus.stall); end
    n_vec++; if (bus.mem_read !== 1'b0) begin n_bad++; $display("FAIL rst_mem_read: got %b need 0", bus.mem_read); end
    n_vec++; if (bus.mem_write !== 1'b0) begin n_bad++; $display("FAIL rst_mem_write: got %b need 0", bus.mem_write); end
    n_vec++; if (bus.mem_addr !== 32'h0) begin n_bad++; $display("FAIL rst_mem_addr: got %h need 0", bus.mem_addr); end
    n_vec++; if (bus.mem_wdata !== 32'h0) begin n_bad++; $display("FAIL rst_mem_wdata: got %h need 0", bus.mem_wdata); end
    n_vec++; if (bus.readData !== 32'h0) begin n_bad++; $display("FAIL rst_readData: got %h need 0", bus.readData); end
`ifdef CACHE_STATS_EN
    n_vec++; if (hit_count !== 32'd0) begin n_bad++; $display("FAIL rst_hit_count: got %0d need 0", hit_count); end
    n_vec++; if (miss_count !== 32'd0) begin n_bad++; $display("FAIL rst_miss_count: got %0d need 0", miss_count); end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_store_miss();
    logic [31:0] f, r; int cyc, w0, r0;
    w0 = wr_cnt; r0 = rd_log.size();
    cpu_op(1'b0, 1'b1, 32'h0, 32'hF0F0_F0F0, f, r, cyc);
    n_vec++; if (cyc !== 3) begin n_bad++; $display("FAIL store_miss_cycles: got %0d need 3", cyc); end
    n_vec++; if (wr_cnt - w0 !== 1) begin n_bad++; $display("FAIL store_miss_beats: got %0d need 1", wr_cnt - w0); end
    n_vec++; if (last_wr_addr !== 32'h0 || last_wr_data !== 32'hF0F0_F0F0) begin
      n_bad++; $display("FAIL store_miss_beat: got %h/%h need 00000000/f0f0f0f0", last_wr_addr, last_wr_data); end
    n_vec++; if (rd_log.size() - r0 !== 0) begin n_bad++; $display("FAIL store_miss_no_read: got %0d reads need 0", rd_log.size() - r0); end
  endtask

  task automatic load_check(input string nm, input logic [31:0] a, input logic [31:0] exp_data, input bit exp_miss);
    logic [31:0] f, r; int cyc, r0;
    r0 = rd_log.size();
    cpu_op(1'b1, 1'b0, a, 32'h0, f, r, cyc);
    n_vec++; if (r !== exp_data) begin n_bad++; $display("FAIL %s_data: got %h need %h", nm, r, exp_data); end
    n_vec++; if (cyc !== (exp_miss ? 9 : 0)) begin n_bad++; $display("FAIL %s_cycles: got %0d need %0d", nm, cyc, exp_miss ? 9 : 0); end
    n_vec++; if (rd_log.size() - r0 !== (exp_miss ? 4 : 0)) begin
      n_bad++; $display("FAIL %s_beats: got %0d need %0d", nm, rd_log.size() - r0, exp_miss ? 4 : 0); end
    if (exp_miss) begin
      n_vec++; if (f !== 32'h0) begin n_bad++; $display("FAIL %s_stalled_readData: got %h need 0", nm, f); end
      for (int k = 0; k < 4; k++) begin
        n_vec++;
        if (rd_log.size() < r0 + 4 || rd_log[r0 + k] !== ((a & 32'hFFFF_FFF0) + 32'(4 * k))) begin
          n_bad++; $display("FAIL %s_beat_addr%0d: got %h need %h", nm, k,
                            (rd_log.size() > r0 + k) ? rd_log[r0 + k] : 32'hX, (a & 32'hFFFF_FFF0) + 32'(4 * k));
        end
      end
    end
  endtask

  task automatic test_refill();
    load_check("refill0", 32'h0, 32'hF0F0_F0F0, 1'b1);
  endtask

  task automatic test_hit();
    load_check("hit0", 32'h0, 32'hF0F0_F0F0, 1'b0);
  endtask

  task automatic test_conflict();
    logic [31:0] f, r; int cyc, w0;
    w0 = wr_cnt;
    cpu_op(1'b0, 1'b1, 32'h100, 32'h0000_0001, f, r, cyc);
    n_vec++; if (wr_cnt - w0 !== 1 || last_wr_addr !== 32'h100) begin
      n_bad++; $display("FAIL conflict_store: got %0d beats at %h need 1 at 00000100", wr_cnt - w0, last_wr_addr); end
    load_check("still_hit0", 32'h0, 32'hF0F0_F0F0, 1'b0);
    load_check("evict_100", 32'h100, 32'h0000_0001, 1'b1);
    load_check("remiss0", 32'h0, 32'hF0F0_F0F0, 1'b1);
  endtask

  task automatic test_store_hit();
    logic [31:0] f, r; int cyc;
    load_check("fill_100", 32'h100, 32'h0000_0001, 1'b1);
    cpu_op(1'b0, 1'b1, 32'h104, 32'hDEAD_BEEF, f, r, cyc);
    n_vec++; if (last_wr_addr !== 32'h104 || last_wr_data !== 32'hDEAD_BEEF) begin
      n_bad++; $display("FAIL store_hit_beat: got %h/%h need 00000104/deadbeef", last_wr_addr, last_wr_data); end
    load_check("hit_104", 32'h104, 32'hDEAD_BEEF, 1'b0);
  endtask

  task automatic test_rw_both();
    logic [31:0] f, r; int cyc, w0, r0;
    w0 = wr_cnt; r0 = rd_log.size();
    cpu_op(1'b1, 1'b1, 32'h108, 32'h0000_0055, f, r, cyc);
    n_vec++; if (cyc !== 3) begin n_bad++; $display("FAIL rw_both_cycles: got %0d need 3", cyc); end
    n_vec++; if (wr_cnt - w0 !== 1 || rd_log.size() - r0 !== 0) begin
      n_bad++; $display("FAIL rw_both_traffic: got %0d writes %0d reads need 1/0", wr_cnt - w0, rd_log.size() - r0); end
    n_vec++; if (r !== 32'h0) begin n_bad++; $display("FAIL rw_both_readData: got %h need 0", r); end
    load_check("hit_108", 32'h108, 32'h0000_0055, 1'b0);
  endtask

  task automatic test_stats_pre_reset();
`ifdef CACHE_STATS_EN
    n_vec++; if (hit_count !== 32'd8) begin n_bad++; $display("FAIL stats_hits: got %0d need 8", hit_count); end
    n_vec++; if (miss_count !== 32'd4) begin n_bad++; $display("FAIL stats_misses: got %0d need 4", miss_count); end
`endif
  endtask

  task automatic test_reset_mid_refill();
    int k;
    @(negedge clk);
    bus.address = 32'h200; bus.memRead = 1'b1; bus.memWrite = 1'b0;
    k = 0;
    #1;
    while (!(bus.mem_read && bus.mem_addr == 32'h208) && k < 100) begin
      @(negedge clk); #1; k++;
    end
    n_vec++; if (k >= 100) begin n_bad++; $display("FAIL mid_refill_reach_beat2: got no beat at 00000208, need one"); end
    rst = 1'b1;
    #1;
    n_vec++; if (bus.mem_read !== 1'b0) begin n_bad++; $display("FAIL mid_refill_mem_read: got %b need 0", bus.mem_read); end
    n_vec++; if (bus.mem_addr !== 32'h0) begin n_bad++; $display("FAIL mid_refill_mem_addr: got %h need 0", bus.mem_addr); end
`ifdef CACHE_STATS_EN
    n_vec++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
      n_bad++; $display("FAIL mid_refill_stats: got %0d/%0d need 0/0", hit_count, miss_count); end
`endif
    @(negedge clk);
    bus.memRead = 1'b0;
    rst = 1'b0;
    load_check("after_rst_200", 32'h200, 32'hA5A5_0200, 1'b1);
    load_check("after_rst_0", 32'h0, 32'hF0F0_F0F0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_store_miss();
    test_refill();
    test_hit();
    test_conflict();
    test_store_hit();
    test_rw_both();
    test_stats_pre_reset();
    test_reset_mid_refill();
    n_vec++;
    if (both_seen !== 1'b0) begin n_bad++; $display("FAIL mem_read_and_write_together: got %b need 0", both_seen); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/data_cache.md
Name: data_cache

Overview:
- Parametrised direct-mapped, write-through, no-write-allocate data cache between the MIPS datapath's memory stage and the DataMemory backing store.
- The CPU side keeps the same address/writeData/memWrite/memRead/readData signals, plus a stall output.
- The memory side is a word-wide request/ready handshake, so backing memory may take any number of cycles.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, word width; must be a multiple of 8.
- LINES, 16, number of cache lines; power of two.
- WORDS_PER_LINE, 4, words per line; power of two, at least 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- address  in  ADDR_W  CPU byte address, word aligned.
- writeData  in  DATA_W  CPU store data.
- memWrite  in  1  store request.
- memRead  in  1  load request.
- readData  out  DATA_W  load data; valid when memRead=1 and stall=0.
- stall  out  1  CPU must hold its request stable while this is high.
- mem_addr  out  ADDR_W  backing-store word address (byte address).
- mem_wdata  out  DATA_W  backing-store write data.
- mem_read  out  1  backing-store read request.
- mem_write  out  1  backing-store write request.
- mem_rdata  in  DATA_W  backing-store read data; valid when mem_ready=1.
- mem_ready  in  1  completes the current mem_read or mem_write beat.

Behaviour:
- Address split, LSB upward:
  - byte offset: log2(DATA_W/8) bits;
  - word offset: log2(WORDS_PER_LINE) bits;
  - index: log2(LINES) bits;
  - tag: remaining bits.
- Per-line storage: valid bit, tag, WORDS_PER_LINE data words.
- hit = valid[index] && tag[index] == address tag.
- If memWrite and memRead are both high, memWrite wins; the request is treated as a store only.
- FSM states: IDLE, REFILL, WRITE.
- IDLE:
  - Load hit: readData is combinational from the array, stall=0, zero-wait.
  - Load miss: stall=1 combinationally; next state REFILL; beat counter=0.
  - Store (hit or miss): stall=1; next state WRITE; drive mem_write=1 with mem_addr=address, mem_wdata=writeData.
  - A store hit updates the cached word on entry to WRITE.
  - A store miss leaves the cache unchanged (no allocate).
- REFILL:
  - Drive mem_read=1 and mem_addr={tag,index,beat,byte-offset 0}.
  - On each mem_ready: write mem_rdata into the line at word index beat, then beat++.
  - On the last beat's mem_ready: set valid and tag, return to IDLE.
  - The next cycle is a hit with stall=0.
  - The entire line is overwritten (conflict eviction needs no writeback, since the cache is write-through).
- WRITE:
  - Hold mem_write, mem_addr and mem_wdata until mem_ready.
  - Then return to IDLE with stall=0 for one cycle, completing the store.
  - If memWrite is still asserted in that cycle, the CPU issued a new store.
- stall = (memRead||memWrite) && !(state==IDLE && memRead && !memWrite && hit), plus the completion rule above.
  - In the completion cycle after WRITE, stall=0 regardless of request.
  - In the cycle after REFILL, the request re-evaluates as a hit.
- mem_read and mem_write are never high simultaneously.
- mem_ready outside REFILL/WRITE is ignored.
- Reset values (apply immediately, asynchronously):
  - all valid bits=0, state=IDLE, beat=0;
  - mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0;
  - readData=0 while stall=1 or no request.
- Reset mid-REFILL or mid-WRITE: the transaction is abandoned and the partially filled line stays invalid.
- The data array is not reset.

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined: adds outputs hit_count (32) and miss_count (32), reset to 0, saturating at all-ones.
  - hit_count increments once per completed load hit from IDLE.
  - miss_count increments once per IDLE-to-REFILL transition.
  - Stores are not counted.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package cache_pkg holds:
  - FSM state enum (IDLE, REFILL, WRITE);
  - localparam helpers for offset, index and tag widths, derived via $clog2;
  - an address-field extraction function.
- One natural sub-module, cache_line_array:
  - valid/tag/data storage;
  - combinational read port (index, word) returning tag, valid and word;
  - one synchronous write port (word write or tag+valid set);
  - asynchronous valid clear.
- The FSM and handshake stay in data_cache.

Test Plan:
- Defaults, memory with 2-cycle mem_ready:
  - Store 0xF0F0F0F0 to 0x0000_0000 → one mem_write beat at 0x0, stall high until ready, no line allocated.
  - Load 0x0 → 4 mem_read beats at 0x0, 0x4, 0x8, 0xC; readData=0xF0F0F0F0 once stall drops.
- Repeat load 0x0 → stall=0 in the same cycle, readData=0xF0F0F0F0, no mem_read.
- Store 0x00000001 to 0x0000_0100 (index 0, different tag) → write-through only; load 0x0 still hits.
  - Then load 0x100 → refill evicts line 0, readData=0x1.
  - Load 0x0 misses again.
- Store hit: store 0xDEADBEEF to 0x104 → mem_write issued; load 0x104 hits with 0xDEADBEEF.
- Simultaneous memRead=memWrite=1 at 0x108, data 0x55 → treated as a store only; no refill starts.
- Reset asserted during beat 2 of a refill:
  - mem_read drops immediately;
  - a subsequent load of the same address misses and refills fully.
- With CACHE_STATS_EN defined, after the sequence above → hit_count and miss_count match the scoreboard; both are 0 after reset.
